// File: rtl/terrain_pkg.sv
// Terrain column SRAM geometry shared by the terrain generator and reader.
// Each column is one 512-bit word; bit r set means row r is solid.
package terrain_pkg;
    localparam logic [9:0] NCOLS      = 10'd640;
    localparam logic [9:0] FLOOR      = 10'd479;
    localparam logic [9:0] NO_HEIGHT  = 10'd480;
    localparam int         ROWS       = 480;
    localparam int         WORD_W     = 512;
    localparam int         CHUNK_W    = 32;
    localparam int         NCHUNKS    = 15;
    localparam logic [3:0] LAST_CHUNK = 4'd14;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        Q_READ = 3'd1,
        Q_WAIT = 3'd2,
        Q_SCAN = 3'd3,
        DONE   = 3'd4
    } q_state_t;
endpackage

// File: rtl/chunk_prio_enc.sv
// Lowest-set-bit encoder over one scan chunk of a terrain column.
module chunk_prio_enc
    import terrain_pkg::*;
(
    input  logic [CHUNK_W-1:0] bits,
    output logic               hit,
    output logic [4:0]         idx
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                hit = 1'b1;
                idx = 5'(i);
            end
        end
    end
endmodule

// File: rtl/terrain_reader.sv
// Read-side client of the terrain SRAM: 2-cycle pixel lookups with priority,
// plus a chunked surface-height query engine sharing the same read port.
module terrain_reader
    import terrain_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_req,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic              pix_valid,
    output logic              pix_terrain,
    input  logic              q_req,
    input  logic [9:0]        q_x,
    output logic              q_busy,
    output logic              q_done,
    output logic [9:0]        q_height,
    output logic [9:0]        sram_read_addr,
    input  logic [WORD_W-1:0] sram_q
);
    q_state_t                          state;
    logic [9:0]                        q_x_lat;
    logic [9:0]                        addr_hold;
    logic [NCHUNKS-1:0][CHUNK_W-1:0]   word;
    logic [3:0]                        chunk;
    logic                              pix_req_d1;
    logic                              pix_in_d1;
    logic [8:0]                        pix_y_d1;
    logic                              pix_in;
    logic                              q_issue;
    logic                              hit;
    logic [4:0]                        idx;

    assign pix_in  = (pix_x < NCOLS) && (pix_y <= FLOOR);
    assign q_issue = (state == Q_READ) && !pix_req;
    assign q_busy  = (state != IDLE);
    assign q_done  = (state == DONE);

    // Pixel lookups always win the port; otherwise the address is held.
    always_comb begin
        sram_read_addr = addr_hold;
        if (pix_req)
            sram_read_addr = pix_x;
        else if (q_issue)
            sram_read_addr = q_x_lat;
    end

    chunk_prio_enc u_enc (
        .bits (word[chunk]),
        .hit  (hit),
        .idx  (idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_hold   <= '0;
            pix_req_d1  <= 1'b0;
            pix_in_d1   <= 1'b0;
            pix_y_d1    <= '0;
            pix_valid   <= 1'b0;
            pix_terrain <= 1'b0;
        end else begin
            addr_hold   <= sram_read_addr;
            pix_req_d1  <= pix_req;
            pix_in_d1   <= pix_req && pix_in;
            pix_y_d1    <= pix_y[8:0];
            pix_valid   <= pix_req_d1;
            pix_terrain <= pix_req_d1 && pix_in_d1 && sram_q[pix_y_d1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            q_x_lat  <= '0;
            word     <= '0;
            chunk    <= '0;
            q_height <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (q_req) begin
                        q_x_lat <= q_x;
                        if (q_x >= NCOLS) begin
                            q_height <= NO_HEIGHT;
                            state    <= DONE;
                        end else begin
                            state <= Q_READ;
                        end
                    end
                end
                Q_READ: if (!pix_req) state <= Q_WAIT;
                // sram_q here answers the Q_READ address, whatever pix_req does now.
                Q_WAIT: begin
                    word  <= sram_q[ROWS-1:0];
                    chunk <= '0;
                    state <= Q_SCAN;
                end
                Q_SCAN: begin
                    if (hit) begin
                        q_height <= {1'b0, chunk, idx};
                        state    <= DONE;
                    end else if (chunk == LAST_CHUNK) begin
                        q_height <= NO_HEIGHT;
                        state    <= DONE;
                    end else begin
                        chunk <= chunk + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_terrain_reader.sv
// Randomized bench for terrain_reader against a row-scan reference model of the terrain memory.
module tb_terrain_reader;
    logic         clk;
    logic         reset_n;
    logic         pix_req;
    logic [9:0]   pix_x;
    logic [9:0]   pix_y;
    logic         pix_valid;
    logic         pix_terrain;
    logic         q_req;
    logic [9:0]   q_x;
    logic         q_busy;
    logic         q_done;
    logic [9:0]   q_height;
    logic [9:0]   sram_read_addr;
    logic [511:0] sram_q;

    logic [511:0] mem [0:1023];
    int           n_chk;
    int           n_pass;
    int           edge_n;
    bit           exp_v [0:16383];
    bit           exp_t [0:16383];

    terrain_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pix_req        (pix_req),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_valid      (pix_valid),
        .pix_terrain    (pix_terrain),
        .q_req          (q_req),
        .q_x            (q_x),
        .q_busy         (q_busy),
        .q_done         (q_done),
        .q_height       (q_height),
        .sram_read_addr (sram_read_addr),
        .sram_q         (sram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1-cycle-latency SRAM
    always @(posedge clk) sram_q <= mem[sram_read_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit model_pix(input logic [9:0] x, input logic [9:0] y);
        if (x >= 10'd640 || y > 10'd479) return 1'b0;
        return mem[x][y[8:0]];
    endfunction

    function automatic int ref_height(input logic [9:0] x);
        if (x >= 10'd640) return 480;
        for (int r = 0; r < 480; r++)
            if (mem[x][r]) return r;
        return 480;
    endfunction

    function automatic logic [511:0] rnd_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Pixel scoreboard: a request seen at edge P is due after edge P+1.
    always @(posedge clk) begin
        edge_n++;
        if (pix_req && edge_n + 1 < 16384) begin
            exp_v[edge_n + 1] = 1'b1;
            exp_t[edge_n + 1] = model_pix(pix_x, pix_y);
        end
    end

    always @(negedge clk) begin
        if (reset_n && edge_n < 16384) begin
            chk("pix_valid", pix_valid, exp_v[edge_n]);
            if (exp_v[edge_n]) chk("pix_terrain", pix_terrain, exp_t[edge_n]);
        end
    end

    task automatic drive_pix(input bit req);
        pix_req = req;
        pix_x   = 10'($urandom_range(0, 700));
        pix_y   = 10'($urandom_range(0, 600));
        if (req) begin
            #1 chk("pix_addr", sram_read_addr, pix_x);
        end
    endtask

    task automatic pix_probe(input logic [9:0] x, input logic [9:0] y, input bit exp);
        @(negedge clk);
        pix_req = 1'b1; pix_x = x; pix_y = y;
        #1 chk("probe_addr", sram_read_addr, x);
        @(negedge clk);
        pix_req = 1'b0;
        @(negedge clk);
        chk("probe_valid", pix_valid, 1);
        chk("probe_terrain", pix_terrain, exp);
    endtask

    // Query issued at cycle 0; done expected at cycle L plus one per pixel stall in the read slot.
    task automatic run_query(input logic [9:0] x, input int force_n, input int pct);
        int h, lat, stalls, tot;
        bit reading, r;
        h       = ref_height(x);
        lat     = (x >= 10'd640) ? 1 : 4 + ((h >= 480) ? 14 : h / 32);
        stalls  = 0;
        reading = (x < 10'd640);
        @(negedge clk);
        q_req = 1'b1;
        q_x   = x;
        drive_pix($urandom_range(0, 99) < pct);
        for (int j = 1; j <= lat + stalls + 1; j++) begin
            @(negedge clk);
            tot = lat + stalls;
            chk("q_busy", q_busy, j <= tot);
            chk("q_done", q_done, j == tot);
            if (j >= tot) chk("q_height", q_height, h);
            q_req = (j <= tot) ? ($urandom_range(0, 3) == 0) : 1'b0;
            q_x   = 10'($urandom);
            r = (j <= force_n) ? 1'b1 : ($urandom_range(0, 99) < pct);
            drive_pix(r);
            if (reading) begin
                if (r) stalls++;
                else begin
                    reading = 1'b0;
                    #1 chk("q_read_addr", sram_read_addr, x);
                end
            end
        end
        pix_req = 1'b0;
        q_req   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_terrain"}, pix_terrain, 0);
        chk({tag, "_q_busy"}, q_busy, 0);
        chk({tag, "_q_done"}, q_done, 0);
        chk({tag, "_q_height"}, q_height, 0);
        chk({tag, "_addr"}, sram_read_addr, 0);
    endtask

    initial begin
        int h;
        logic [511:0] w;
        n_chk = 0; n_pass = 0; edge_n = 0;
        reset_n = 1'b0; pix_req = 1'b0; pix_x = '0; pix_y = '0; q_req = 1'b0; q_x = '0;

        for (int c = 0; c < 1024; c++) begin
            if (c >= 640) mem[c] = '1;
            else begin
                w = rnd_word();
                h = $urandom_range(0, 520);
                for (int r = 0; r < 480; r++) if (r < h) w[r] = 1'b0;
                if (h < 480) w[h] = 1'b1;
                mem[c] = w;
            end
        end
        mem[0] = '0; mem[0][300] = 1'b1;
        mem[1] = '0; mem[1][0] = 1'b1;
        mem[2] = '0; mem[2][31] = 1'b1;
        mem[3] = '0; mem[3][32] = 1'b1;
        mem[5] = '0; for (int r = 310; r < 480; r++) mem[5][r] = 1'b1;
        mem[7] = '0;
        mem[8] = '0; mem[8][511:480] = '1;
        mem[9] = '0; mem[9][479] = 1'b1; mem[9][511:480] = '1;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        pix_probe(10'd0, 10'd300, 1'b1);
        pix_probe(10'd0, 10'd299, 1'b0);
        pix_probe(10'd650, 10'd10, 1'b0);
        pix_probe(10'd9, 10'd479, 1'b1);
        pix_probe(10'd9, 10'd480, 1'b0);

        run_query(10'd5, 0, 0);
        run_query(10'd7, 0, 0);
        run_query(10'd5, 5, 0);
        run_query(10'd700, 0, 0);
        run_query(10'd8, 0, 0);
        run_query(10'd1, 0, 0);
        run_query(10'd2, 0, 0);
        run_query(10'd3, 0, 0);
        run_query(10'd9, 0, 30);
        run_query(10'd639, 0, 30);
        run_query(10'd640, 0, 50);

        // Reset in the middle of a scan: nothing may complete.
        @(negedge clk);
        q_req = 1'b1; q_x = 10'd5;
        @(negedge clk);
        q_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("scan_busy", q_busy, 1);
        reset_n = 1'b0;
        #1 chk_all_zero("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", q_done, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", q_busy, 0);
        chk("abort_nodone", q_done, 0);
        run_query(10'd5, 0, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) run_query(10'($urandom_range(640, 1023)), 0, 40);
            else run_query(10'($urandom_range(0, 639)), 0, $urandom_range(0, 70));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
